// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared FSM state type and saturating-counter constants for the gshare predictor
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // Weakly not-taken value written by the initialisation sweep (01 for a 2-bit counter).
  function automatic int ctr_reset_val(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Strongly taken / saturation ceiling.
  function automatic int ctr_max_val(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - combinational saturating counter next-state for table training
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] count,
  input  logic             taken,
  input  logic             force_max,
  output logic [CTR_W-1:0] next_count
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max_val(CTR_W));

  // Jumps force strongly taken; branches step toward their outcome and stick at the rails.
  always_comb begin
    next_count = count;
    if (force_max) begin
      next_count = CTR_MAX;
    end else if (taken) begin
      if (count != CTR_MAX) next_count = count + CTR_W'(1);
    end else begin
      if (count != '0) next_count = count - CTR_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor top; optional GSHARE_STATS_EN adds lookup/mispredict counters
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int IDX_W  = 10,
  parameter int HIST_W = 10,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_f,
  input  logic              lookup_f,
  output logic              pred_taken_f,
  output logic [IDX_W-1:0]  pred_idx_f,
  output logic [HIST_W-1:0] pred_ghr_f,
  output logic              ready,
  input  logic              upd_branch_e,
  input  logic              upd_jump_e,
  input  logic              upd_taken_e,
  input  logic [IDX_W-1:0]  upd_idx_e,
  input  logic [HIST_W-1:0] upd_ghr_e,
  input  logic              upd_mispred_e,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispred
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  bp_state_t         state;
  bp_state_t         state_next;
  logic [IDX_W-1:0]  ptr;
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_rec;
  logic [IDX_W-1:0]  ghr_ext;
  logic [IDX_W-1:0]  idx;
  logic [CTR_W-1:0]  tbl [DEPTH];
  logic [CTR_W-1:0]  upd_next;
  logic              upd_any;
  logic              recover;
  logic              do_lookup;
  logic              unused_bits;

  // Only a window of the PC and the low history bits feed the logic.
  assign unused_bits = ^{pc_f, upd_ghr_e};

  assign ready     = (state == RUN);
  assign upd_any   = upd_branch_e | upd_jump_e;
  assign recover   = ready & upd_mispred_e & upd_any;
  assign do_lookup = ready & lookup_f;

  // History sits in the low index bits; upper bits are zero when HIST_W < IDX_W.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr;
  end

  assign idx          = pc_f[PC_LSB +: IDX_W] ^ ghr_ext;
  assign pred_taken_f = tbl[idx][CTR_W-1] & ready;
  assign pred_idx_f   = idx;
  assign pred_ghr_f   = ghr;

  if (HIST_W > 1) begin : g_shift
    assign ghr_spec = {ghr[HIST_W-2:0], pred_taken_f};
    assign ghr_rec  = {upd_ghr_e[HIST_W-2:0], upd_taken_e | upd_jump_e};
  end else begin : g_shift1
    assign ghr_spec = pred_taken_f;
    assign ghr_rec  = upd_taken_e | upd_jump_e;
  end

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .count      (tbl[upd_idx_e]),
    .taken      (upd_taken_e),
    .force_max  (upd_jump_e & ~upd_branch_e),
    .next_count (upd_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // Leave the sweep once the last entry has been written.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (ptr == PTR_LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Sweep pointer advances every INIT cycle.
  always_ff @(posedge clk) begin
    if (rst)                ptr <= '0;
    else if (state == INIT) ptr <= ptr + IDX_W'(1);
  end

  // Recovery from E takes priority over the speculative fetch shift.
  always_ff @(posedge clk) begin
    if (rst)            ghr <= '0;
    else if (recover)   ghr <= ghr_rec;
    else if (do_lookup) ghr <= ghr_spec;
  end

  // Table writes: sweep during INIT, training from E once running.
  always_ff @(posedge clk) begin
    if (state == INIT)  tbl[ptr] <= CTR_INIT;
    else if (upd_any)   tbl[upd_idx_e] <= upd_next;
  end

`ifdef GSHARE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (do_lookup && stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (recover && stat_mispred != '1)   stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare_predictor (default parameters)
module tb_gshare_predictor;

  localparam int S_READY = 0;
  localparam int S_PRED  = 1;
  localparam int S_IDX   = 2;
  localparam int S_GHR   = 3;
  localparam int S_LK    = 4;
  localparam int S_MP    = 5;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        lookup_f;
  logic        pred_taken_f;
  logic [9:0]  pred_idx_f;
  logic [9:0]  pred_ghr_f;
  logic        ready;
  logic        upd_branch_e;
  logic        upd_jump_e;
  logic        upd_taken_e;
  logic [9:0]  upd_idx_e;
  logic [9:0]  upd_ghr_e;
  logic        upd_mispred_e;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;

  gshare_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .lookup_f     (lookup_f),
    .pred_taken_f (pred_taken_f),
    .pred_idx_f   (pred_idx_f),
    .pred_ghr_f   (pred_ghr_f),
    .ready        (ready),
    .upd_branch_e (upd_branch_e),
    .upd_jump_e   (upd_jump_e),
    .upd_taken_e  (upd_taken_e),
    .upd_idx_e    (upd_idx_e),
    .upd_ghr_e    (upd_ghr_e),
    .upd_mispred_e(upd_mispred_e),
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  logic [1:0]  m_tbl [1024];
  logic [9:0]  m_ghr;
  logic [31:0] m_lk;
  logic [31:0] m_mp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int sel, input string tag, input logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_READY: return {31'd0, ready};
      S_PRED:  return {31'd0, pred_taken_f};
      S_IDX:   return {22'd0, pred_idx_f};
      S_GHR:   return {22'd0, pred_ghr_f};
      S_LK:    return stat_lookups;
      default: return stat_mispred;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  // One RUN-mode cycle: drive, predict from the model, compare at negedge, advance the model.
  task automatic step(input logic [31:0] pc, input logic lk, input logic br, input logic jp,
                      input logic tk, input logic [9:0] ui, input logic [9:0] ug, input logic mp);
    logic [31:0] pcv;
    logic [9:0]  mi;
    logic        mpred;
    logic [1:0]  c;
    pc_f = pc; lookup_f = lk; upd_branch_e = br; upd_jump_e = jp;
    upd_taken_e = tk; upd_idx_e = ui; upd_ghr_e = ug; upd_mispred_e = mp;
    pcv = pc;
    mi = pcv[11:2] ^ m_ghr;
    mpred = m_tbl[mi][1];
    push_exp(S_READY, "ready", 32'd1);
    push_exp(S_PRED, "pred_taken", {31'd0, mpred});
    push_exp(S_IDX, "pred_idx", {22'd0, mi});
    push_exp(S_GHR, "pred_ghr", {22'd0, m_ghr});
    push_exp(S_LK, "stat_lookups", m_lk);
    push_exp(S_MP, "stat_mispred", m_mp);
    @(negedge clk);
    drain();
    @(posedge clk);
    c = m_tbl[ui];
    if (br)      m_tbl[ui] = tk ? ((c == 2'd3) ? c : c + 2'd1) : ((c == 2'd0) ? c : c - 2'd1);
    else if (jp) m_tbl[ui] = 2'd3;
`ifdef GSHARE_STATS_EN
    if (lk) m_lk++;
    if (mp && (br || jp)) m_mp++;
`endif
    if (mp && (br || jp)) m_ghr = {ug[8:0], tk | jp};
    else if (lk)          m_ghr = {m_ghr[8:0], mpred};
    #1;
    lookup_f = 0; upd_branch_e = 0; upd_jump_e = 0; upd_mispred_e = 0;
  endtask

  task automatic idle(input logic [31:0] pc);
    step(pc, 0, 0, 0, 0, 10'd0, 10'd0, 0);
  endtask

  // Count edges after reset release until ready, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 1100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  int cnt;

  initial begin
    checks = 0; failures = 0;
    rst = 1; pc_f = 32'h14; lookup_f = 0; upd_branch_e = 0; upd_jump_e = 0;
    upd_taken_e = 0; upd_idx_e = 0; upd_ghr_e = 0; upd_mispred_e = 0;
    m_ghr = 0; m_lk = 0; m_mp = 0;

    @(posedge clk); #1;
    push_exp(S_READY, "rst_ready", 32'd0);
    push_exp(S_PRED, "rst_pred", 32'd0);
    push_exp(S_GHR, "rst_ghr", 32'd0);
    push_exp(S_IDX, "rst_idx", 32'd5);
    push_exp(S_LK, "rst_stat_lk", 32'd0);
    push_exp(S_MP, "rst_stat_mp", 32'd0);
    @(negedge clk); drain();
    @(posedge clk); #1;

    // Sweep with traffic that must be ignored.
    rst = 0; lookup_f = 1; upd_branch_e = 1; upd_taken_e = 1; upd_mispred_e = 1;
    upd_ghr_e = 10'h155; upd_idx_e = 10'd7;
    wait_ready(cnt);
    lookup_f = 0; upd_branch_e = 0; upd_taken_e = 0; upd_mispred_e = 0;
    check_eq("sweep_len", cnt, 32'd1024);
    for (int i = 0; i < 1024; i++) m_tbl[i] = 2'b01;
    push_exp(S_GHR, "sweep_ghr", 32'd0);
    push_exp(S_LK, "sweep_stat_lk", 32'd0);
    push_exp(S_MP, "sweep_stat_mp", 32'd0);

    // Freshly initialised entries predict not-taken.
    idle(32'h0);
    idle(32'h14);
    idle(32'hFFC);
    idle(32'h48C);

    // Saturation on idx 5.
    for (int i = 0; i < 4; i++) step(32'h14, 0, 1, 0, 1, 10'd5, 10'd0, 0);
    push_exp(S_PRED, "sat_top", 32'd1);
    for (int i = 0; i < 4; i++) step(32'h14, 0, 1, 0, 0, 10'd5, 10'd0, 0);
    push_exp(S_PRED, "sat_floor_nt", 32'd0);
    step(32'h14, 0, 1, 0, 1, 10'd5, 10'd0, 0);
    push_exp(S_PRED, "sat_floor_01", 32'd0);
    step(32'h14, 0, 1, 0, 1, 10'd5, 10'd0, 0);
    push_exp(S_PRED, "sat_climb_10", 32'd1);
    idle(32'h14);

    // Jump forces strongly taken; branch rule wins when both are set.
    step(32'hFFC, 0, 0, 1, 0, 10'h3FF, 10'd0, 0);
    push_exp(S_PRED, "jump_max", 32'd1);
    push_exp(S_GHR, "jump_ghr", 32'd0);
    step(32'hFFC, 0, 1, 0, 0, 10'h3FF, 10'd0, 0);
    step(32'hFFC, 0, 1, 0, 0, 10'h3FF, 10'd0, 0);
    step(32'hFFC, 0, 1, 1, 0, 10'h3FF, 10'd0, 0);
    push_exp(S_PRED, "jump_vs_branch", 32'd0);
    idle(32'hFFC);

    // Speculative history: train idx 0x100 and 0x102 taken, leave 0x101 weak.
    for (int i = 0; i < 2; i++) step(32'h0, 0, 1, 0, 1, 10'h100, 10'd0, 0);
    for (int i = 0; i < 2; i++) step(32'h0, 0, 1, 0, 1, 10'h102, 10'd0, 0);
    push_exp(S_GHR, "spec_ghr0", 32'd0);
    push_exp(S_PRED, "spec_pred0", 32'd1);
    step(32'h400, 1, 0, 0, 0, 10'd0, 10'd0, 0);
    push_exp(S_GHR, "spec_ghr1", 32'd1);
    push_exp(S_PRED, "spec_pred1", 32'd0);
    step(32'h400, 1, 0, 0, 0, 10'd0, 10'd0, 0);
    push_exp(S_GHR, "spec_ghr2", 32'd2);
    push_exp(S_PRED, "spec_pred2", 32'd1);
    step(32'h400, 1, 0, 0, 0, 10'd0, 10'd0, 0);
    push_exp(S_GHR, "spec_ghr_final", 32'h005);

    // Recovery overrides the same-cycle speculative shift.
    step(32'h400, 1, 1, 0, 1, 10'h200, 10'h0F0, 1);
    push_exp(S_GHR, "recover_ghr", 32'h1E1);
    idle(32'h0);

    // Mispredict flag without an update is not a recovery.
    step(32'h0, 0, 0, 0, 1, 10'd0, 10'h2AA, 1);

    // Remaining traffic for the statistics counters.
    for (int i = 0; i < 3; i++) step(32'h800 + 32'(i * 4), 1, 0, 0, 0, 10'd0, 10'd0, 0);
    step(32'h0, 0, 0, 1, 0, 10'h010, 10'h3FF, 1);
    push_exp(S_GHR, "jump_recover_ghr", 32'h3FF);
`ifdef GSHARE_STATS_EN
    push_exp(S_LK, "stat_lookups_7", 32'd7);
    push_exp(S_MP, "stat_mispred_2", 32'd2);
`else
    push_exp(S_LK, "stat_lookups_off", 32'd0);
    push_exp(S_MP, "stat_mispred_off", 32'd0);
`endif
    idle(32'h0);

    // Reset mid-run, then again mid-sweep.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (500) begin
      @(posedge clk); #1;
    end
    check_eq("midsweep_ready", {31'd0, ready}, 32'd0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    wait_ready(cnt);
    check_eq("resweep_len", cnt, 32'd1024);
    push_exp(S_GHR, "resweep_ghr", 32'd0);
    push_exp(S_PRED, "resweep_pred", 32'd0);
    push_exp(S_LK, "resweep_stat_lk", 32'd0);
    push_exp(S_MP, "resweep_stat_mp", 32'd0);
    @(negedge clk); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare direction predictor for the fetch stage of the RISC-V pipeline; next-generation replacement for the fixed 1024×2-bit pattern history table. XORs a speculatively updated global history register (GHR) with fetch PC bits to index a table of CTR_W-bit saturating counters. Trains from execute-stage resolution and recovers history on mispredict. Initialises the table with a sequential sweep instead of a single-cycle clear.

## Interface
- PC_W, 32, PC width
- PC_LSB, 2, PC bits dropped below the index (instruction alignment)
- IDX_W, 10, table index width; depth = 2^IDX_W
- HIST_W, 10, GHR length; legal range 1..IDX_W
- CTR_W, 2, saturating counter width; legal range 2..4

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- pc_f  in  PC_W  fetch PC
- lookup_f  in  1  fetch is a conditional branch or jump; advance speculative GHR
- pred_taken_f  out  1  predicted direction (counter MSB); 0 while !ready
- pred_idx_f  out  IDX_W  table index used; carried down the pipe
- pred_ghr_f  out  HIST_W  GHR before this lookup's shift; carried down the pipe
- ready  out  1  table initialised; 0 during sweep
- upd_branch_e  in  1  resolved conditional branch in E
- upd_jump_e  in  1  resolved jump in E (ignored if upd_branch_e is also 1)
- upd_taken_e  in  1  actual direction
- upd_idx_e  in  IDX_W  pred_idx_f carried from F
- upd_ghr_e  in  HIST_W  pred_ghr_f carried from F
- upd_mispred_e  in  1  direction or jump mispredicted; restore GHR
- stat_lookups  out  32  lookup counter (see Configuration)
- stat_mispred  out  32  mispredict counter (see Configuration)

## Operation
- Index: idx = pc_f[PC_LSB +: IDX_W] XOR zero-extended GHR (GHR occupies low HIST_W bits).
- Read: combinational from pc_f and GHR; pred_taken_f = table[idx][CTR_W-1] & ready.
- Counter update on upd_branch_e: taken -> min(c+1, 2^CTR_W-1); not taken -> max(c-1, 0). Never wraps.
- Jump update on upd_jump_e: counter written to 2^CTR_W-1.
- Speculative history: lookup_f & ready -> GHR <= {GHR[HIST_W-2:0], pred_taken_f}.
- Recovery: upd_mispred_e & (upd_branch_e | upd_jump_e) -> GHR <= {upd_ghr_e[HIST_W-2:0], upd_taken_e | upd_jump_e}. Overrides any same-cycle speculative shift.
- Without mispredict, E never modifies GHR.
- FSM states INIT, RUN.
  - rst -> INIT, sweep pointer 0, GHR 0.
  - INIT: each cycle writes table[ptr] = 2^(CTR_W-1)-1 (weakly not-taken, 01 at CTR_W=2) and increments ptr.
  - At ptr = 2^IDX_W-1, the last write occurs and the FSM enters RUN on the next edge.
  - In INIT, all updates and lookups are ignored and GHR stays 0.
  - RUN: ready=1; remains in RUN until rst.
- rst asserted mid-sweep or mid-run restarts the sweep from ptr 0.

## Timing
- Reset values: ready=0, pred_taken_f=0, GHR=0 (so pred_ghr_f=0), stat_* = 0. pred_idx_f = pc_f bits XOR 0.
- Sweep length: exactly 2^IDX_W cycles after rst deasserts; ready rises on cycle 2^IDX_W (1024 at default).
- Prediction latency: 0 cycles (same-cycle combinational).
- Table write: visible to reads from the edge after the update cycle. Same-cycle read of the index being written returns the old value.
- GHR shift and recovery take effect at the next edge.

## Configuration
- GSHARE_STATS_EN defined:
  - stat_lookups increments on lookup_f & ready.
  - stat_mispred increments on upd_mispred_e & (upd_branch_e | upd_jump_e) & ready.
  - Both counters saturate at 2^32-1 and clear on rst.
- Not defined: both ports are tied to 0 and no counter logic is instantiated.

## Structure
- Package bp_pkg: FSM state enum (INIT, RUN), counter-reset-value and counter-max constant functions of CTR_W.
- One sub-module, bp_sat_ctr: combinational CTR_W-bit saturating next-state (inputs: count, taken, force_max; output: next count). Instantiated once, on the update path.

## Test plan
- Reset sweep: rst for 2 cycles, then release -> ready=0 for 1024 cycles, 1 on cycle 1024; sampled entries read 01 and pred_taken_f=0.
- Saturation: 4 taken updates to idx 5 -> counter 01→10→11→11 and pred_taken_f=1 at matching pc_f; then 4 not-taken -> 11→10→01→00→00.
- Speculative GHR: ready, GHR=0, 3 lookups predicting 1,0,1 -> GHR=0b101 and pred_ghr_f sequence 0, 1, 2.
- Recovery: upd_mispred_e with upd_ghr_e=0x0F0, upd_taken_e=1, same-cycle lookup_f=1 -> GHR=0x1E1 (recovery wins).
- Jump: upd_jump_e at idx 0x3FF -> counter 11 and GHR unchanged without mispred; with upd_branch_e also high -> branch rule applies.
- Reset mid-sweep: rst at sweep cycle 500 -> ready stays 0 and ready rises exactly 1024 cycles after the release. With GSHARE_STATS_EN, 7 lookups and 2 mispredicts give stat_lookups=7 and stat_mispred=2; without the macro, both read 0.
